// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one SRAM-style memory port between instruction fetch and
//             load/store, with round-robin arbitration and an ack timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  // load/store requester
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  // shared memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                bus_err,
  output logic                stallreq_for_inst,
  output logic                stallreq_for_data
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value during the last BUSY cycle before the transaction is aborted
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_done_q, inst_done_d;
  logic                data_done_q, data_done_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout_hit;
  logic                grant_data;
  logic                in_busy;
  logic                busy_is_data;

  assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  // Data wins when alone, or on contention when inst was served last
  assign grant_data   = data_req && (!inst_req || (last_grant_q == GRANT_INST));
  assign in_busy      = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign busy_is_data = (state_q == ST_BUSY_D);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d      = ST_BUSY_D;
          last_grant_d = GRANT_DATA;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = data_we;
          mem_sel_d    = data_we ? data_sel : {SEL_W{1'b1}};
          mem_addr_d   = data_addr;
          mem_wdata_d  = data_we ? data_wdata : '0;
        end else if (inst_req) begin
          state_d      = ST_BUSY_I;
          last_grant_d = GRANT_INST;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_sel_d    = {SEL_W{1'b1}};
          mem_addr_d   = inst_addr;
          mem_wdata_d  = '0;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (in_busy && (mem_ack || timeout_hit)) begin
          // An ack coincident with the timeout still completes normally
          mem_req_d = 1'b0;
          bus_err_d = !mem_ack;
          if (busy_is_data) begin
            state_d      = ST_DONE_D;
            data_done_d  = 1'b1;
            data_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            state_d      = ST_DONE_I;
            inst_done_d  = 1'b1;
            inst_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE_I, ST_DONE_D: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_INST;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_sel    = mem_sel_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign bus_err    = bus_err_q;

  // Low in the done cycle so the pipeline advances once per completion
  assign stallreq_for_inst = inst_req & ~inst_done_q;
  assign stallreq_for_data = data_req & ~data_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        stallreq_for_inst;
  logic        stallreq_for_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .stallreq_for_inst(stallreq_for_inst), .stallreq_for_data(stallreq_for_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each window starts 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (inst_done !== 1'b0)   begin errors++; $display("FAIL rst_inst_done got %b exp 0", inst_done); end
    checks++; if (data_done !== 1'b0)   begin errors++; $display("FAIL rst_data_done got %b exp 0", data_done); end
    checks++; if (bus_err !== 1'b0)     begin errors++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
    checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL rst_inst_rdata got %h exp 0", inst_rdata); end
    rst = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
    tick();
    checks++; if (mem_req !== 1'b1)           begin errors++; $display("FAIL rst_pre_grant got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rst_pre_addr got %h exp 00000100", mem_addr); end
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_async_mem_req got %b exp 0", mem_req); end
    tick();
    checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b exp 0", data_done); end
    checks++; if (bus_err !== 1'b0)   begin errors++; $display("FAIL rst_no_bus_err got %b exp 0", bus_err); end
    // Both pending right after release: data must win first
    inst_req = 1'b1; inst_addr = 32'h0000_00A0; data_addr = 32'h0000_0200;
    rst = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1)           begin errors++; $display("FAIL rst_regrant_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rst_regrant_addr got %h exp 00000200", mem_addr); end
    checks++; if (mem_sel !== 4'hF)           begin errors++; $display("FAIL rst_regrant_sel got %h exp f", mem_sel); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_ack = 1'b0;
    checks++; if (data_done !== 1'b1)          begin errors++; $display("FAIL rst_load_done got %b exp 1", data_done); end
    checks++; if (data_rdata !== 32'h0000_0055) begin errors++; $display("FAIL rst_load_rdata got %h exp 00000055", data_rdata); end
    data_req = 1'b0;
    tick();
    inst_req = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_idle_req got %b exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_idle2_req got %b exp 0", mem_req); end
  endtask

  task automatic test_fetch();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #1;
    checks++; if (stallreq_for_inst !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", stallreq_for_inst); end
    tick();
    checks++; if (mem_req !== 1'b1)           begin errors++; $display("FAIL fetch_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_addr got %h exp bfc00000", mem_addr); end
    checks++; if (mem_we !== 1'b0)            begin errors++; $display("FAIL fetch_we got %b exp 0", mem_we); end
    checks++; if (mem_sel !== 4'hF)           begin errors++; $display("FAIL fetch_sel got %h exp f", mem_sel); end
    checks++; if (stallreq_for_inst !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %b exp 1", stallreq_for_inst); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h2408_0001;
    checks++; if (stallreq_for_inst !== 1'b1) begin errors++; $display("FAIL fetch_stall_c2 got %b exp 1", stallreq_for_inst); end
    checks++; if (inst_done !== 1'b0)         begin errors++; $display("FAIL fetch_early_done got %b exp 0", inst_done); end
    tick();
    mem_ack = 1'b0;
    checks++; if (inst_done !== 1'b1)           begin errors++; $display("FAIL fetch_done got %b exp 1", inst_done); end
    checks++; if (inst_rdata !== 32'h2408_0001) begin errors++; $display("FAIL fetch_rdata got %h exp 24080001", inst_rdata); end
    checks++; if (stallreq_for_inst !== 1'b0)   begin errors++; $display("FAIL fetch_stall_c3 got %b exp 0", stallreq_for_inst); end
    checks++; if (mem_req !== 1'b0)             begin errors++; $display("FAIL fetch_req_drop got %b exp 0", mem_req); end
    checks++; if (data_done !== 1'b0)           begin errors++; $display("FAIL fetch_wrong_done got %b exp 0", data_done); end
    inst_req = 1'b0;
    tick();
    checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse got %b exp 0", inst_done); end
  endtask

  task automatic test_store();
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0011;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_ABCD;
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      checks++; if (mem_req !== 1'b1)            begin errors++; $display("FAIL store_req[%0d] got %b exp 1", c, mem_req); end
      checks++; if (mem_we !== 1'b1)             begin errors++; $display("FAIL store_we[%0d] got %b exp 1", c, mem_we); end
      checks++; if (mem_sel !== 4'b0011)         begin errors++; $display("FAIL store_sel[%0d] got %b exp 0011", c, mem_sel); end
      checks++; if (mem_addr !== 32'h8000_0010)  begin errors++; $display("FAIL store_addr[%0d] got %h exp 80000010", c, mem_addr); end
      checks++; if (mem_wdata !== 32'h1234_ABCD) begin errors++; $display("FAIL store_wdata[%0d] got %h exp 1234abcd", c, mem_wdata); end
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL store_done got %b exp 1", data_done); end
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL store_req_drop got %b exp 0", mem_req); end
    checks++; if (bus_err !== 1'b0)   begin errors++; $display("FAIL store_bus_err got %b exp 0", bus_err); end
    data_req = 1'b0; data_we = 1'b0;
    tick();
    checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL store_done_pulse got %b exp 0", data_done); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000;
      tick();
      checks++; if (mem_req !== 1'b1)   begin errors++; $display("FAIL cont_req[%0d] got %b exp 1", i, mem_req); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL cont_addr[%0d] got %h exp %h", i, mem_addr, exp_addr); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0000_0100 + i;
      tick();
      mem_ack = 1'b0;
      if (i % 2 == 0) begin
        checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL cont_ddone[%0d] got %b exp 1", i, data_done); end
        checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL cont_idone[%0d] got %b exp 0", i, inst_done); end
        checks++; if (data_rdata !== 32'h0000_0100 + i) begin errors++; $display("FAIL cont_drdata[%0d] got %h exp %h", i, data_rdata, 32'h0000_0100 + i); end
      end else begin
        checks++; if (inst_done !== 1'b1) begin errors++; $display("FAIL cont_idone[%0d] got %b exp 1", i, inst_done); end
        checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL cont_ddone[%0d] got %b exp 0", i, data_done); end
        checks++; if (inst_rdata !== 32'h0000_0100 + i) begin errors++; $display("FAIL cont_irdata[%0d] got %h exp %h", i, inst_rdata, 32'h0000_0100 + i); end
      end
      if (i == 3) begin inst_req = 1'b0; data_req = 1'b0; end
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cont_idle[%0d] got %b exp 0", i, mem_req); end
    end
  endtask

  task automatic test_timeout();
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_3000;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d] got %b exp 1", c, mem_req); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_early_err[%0d] got %b exp 0", c, bus_err); end
    end
    tick();
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL to_req_drop got %b exp 0", mem_req); end
    checks++; if (bus_err !== 1'b1)     begin errors++; $display("FAIL to_bus_err got %b exp 1", bus_err); end
    checks++; if (data_done !== 1'b1)   begin errors++; $display("FAIL to_done got %b exp 1", data_done); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", data_rdata); end
    data_req = 1'b0;
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", bus_err); end
  endtask

  task automatic test_race();
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL race_req[%0d] got %b exp 1", c, mem_req); end
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    checks++; if (inst_done !== 1'b1)           begin errors++; $display("FAIL race_done got %b exp 1", inst_done); end
    checks++; if (inst_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_rdata got %h exp cafef00d", inst_rdata); end
    checks++; if (bus_err !== 1'b0)             begin errors++; $display("FAIL race_bus_err got %b exp 0", bus_err); end
    inst_req = 1'b0;
    tick();
    // Stray ack in IDLE must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    checks++; if (inst_done !== 1'b0 || data_done !== 1'b0) begin errors++; $display("FAIL stray_ack_done got %b%b exp 00", inst_done, data_done); end
    checks++; if (inst_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL stray_ack_rdata got %h exp cafef00d", inst_rdata); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack_req got %b exp 0", mem_req); end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
